// File: rtl/vec_issue_unit_pkg.sv
// Shared types and encodings for the vector issue unit.
package vec_issue_unit_pkg;

  localparam logic [6:0] OPC_VECTOR = 7'b1010111;
  localparam logic [2:0] FNC3_FVV   = 3'b001;

  localparam logic [5:0] FNC6_VADD   = 6'b000000;
  localparam logic [5:0] FNC6_VFMIN  = 6'b000100;
  localparam logic [5:0] FNC6_VFMAX  = 6'b000110;
  localparam logic [5:0] FNC6_VFMUL  = 6'b100100;
  localparam logic [5:0] FNC6_VFMADD = 6'b101000;
  localparam logic [5:0] FNC6_VFMACC = 6'b101100;

  typedef enum logic [2:0] {
    OP_VADD   = 3'd0,
    OP_VFMIN  = 3'd1,
    OP_VFMAX  = 3'd2,
    OP_VFMUL  = 3'd3,
    OP_VFMADD = 3'd4,
    OP_VFMACC = 3'd5
  } vop_e;

  typedef struct packed {
    vop_e       op;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [4:0] vd;
  } viq_entry_t;

  typedef struct packed {
    logic       legal;
    viq_entry_t ent;
  } vdec_t;

  // Decode one OPC_VECTOR word; the vm bit (25) plays no part in legality.
  function automatic vdec_t vdecode(input logic [31:0] inst);
    vdec_t d;
    logic  f6_ok;
    d         = '0;
    f6_ok     = 1'b1;
    d.ent.vs1 = inst[19:15];
    d.ent.vs2 = inst[24:20];
    d.ent.vd  = inst[11:7];
    case (inst[31:26])
      FNC6_VADD:   d.ent.op = OP_VADD;
      FNC6_VFMIN:  d.ent.op = OP_VFMIN;
      FNC6_VFMAX:  d.ent.op = OP_VFMAX;
      FNC6_VFMUL:  d.ent.op = OP_VFMUL;
      FNC6_VFMADD: d.ent.op = OP_VFMADD;
      FNC6_VFMACC: d.ent.op = OP_VFMACC;
      default:     f6_ok    = 1'b0;
    endcase
    d.legal = f6_ok && (inst[6:0] == OPC_VECTOR) && (inst[14:12] == FNC3_FVV);
    return d;
  endfunction

endpackage

// File: rtl/vec_issue_unit_if.sv
// Decode request, regfile read, execute issue and writeback signals.
interface vec_issue_unit_if;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [31:0] io_req_bits_inst;

  logic [4:0]  io_rf_raddr1;
  logic [4:0]  io_rf_raddr2;
  logic [4:0]  io_rf_raddr3;
  logic [31:0] io_rf_rdata1;
  logic [31:0] io_rf_rdata2;
  logic [31:0] io_rf_rdata3;

  logic        io_exe_valid;
  logic [2:0]  io_exe_bits_op;
  logic [31:0] io_exe_bits_a;
  logic [31:0] io_exe_bits_b;
  logic [31:0] io_exe_bits_c;
  logic [4:0]  io_exe_bits_vd;

  logic        io_wb_valid;
  logic [4:0]  io_wb_vd;

  // Environment side: decode, regfile data and execute-unit writeback.
  modport master (
    output io_req_valid, io_req_bits_inst,
    output io_rf_rdata1, io_rf_rdata2, io_rf_rdata3,
    output io_wb_valid, io_wb_vd,
    input  io_req_ready, io_rf_raddr1, io_rf_raddr2, io_rf_raddr3,
    input  io_exe_valid, io_exe_bits_op, io_exe_bits_a, io_exe_bits_b,
    input  io_exe_bits_c, io_exe_bits_vd
  );

  // Issue unit side.
  modport slave (
    input  io_req_valid, io_req_bits_inst,
    input  io_rf_rdata1, io_rf_rdata2, io_rf_rdata3,
    input  io_wb_valid, io_wb_vd,
    output io_req_ready, io_rf_raddr1, io_rf_raddr2, io_rf_raddr3,
    output io_exe_valid, io_exe_bits_op, io_exe_bits_a, io_exe_bits_b,
    output io_exe_bits_c, io_exe_bits_vd
  );
endinterface

// File: rtl/vec_issue_fifo.sv
// Circular issue queue with wrapping pointers and an explicit occupancy count.
module vec_issue_fifo
  import vec_issue_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  viq_entry_t push_data,
  input  logic       pop,
  output viq_entry_t head,
  output logic       empty,
  output logic       full
);

  viq_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until the count covers them.
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= push_data;

  // Pointers and count; flush discards everything not yet issued.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

endmodule

// File: rtl/vec_issue_unit.sv
// In-order vector FP issue: decode check, queue, register scoreboard, issue.
module vec_issue_unit
  import vec_issue_unit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FPU_LAT = 3
) (
  input  logic             clock,
  input  logic             reset,
  vec_issue_unit_if.slave  io,
  input  logic             io_flush,
  output logic             io_illegal,
  output logic             io_busy
);

  // Execute latency is fixed and owned by the FPU; it only has to be sane here.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FPU_LAT < 1) begin : g_bad_param
    $error("vec_issue_unit: DEPTH must be a power of two >= 2, FPU_LAT >= 1");
  end

  vdec_t       dec;
  viq_entry_t  head;
  logic        empty, full;
  logic        enq_fire, issue;
  logic [31:0] sb, sb_set, sb_clr;
  logic        unused_vm;

  assign unused_vm = io.io_req_bits_inst[25];

  assign dec             = vdecode(io.io_req_bits_inst);
  assign io.io_req_ready = !full && !io_flush;
  assign enq_fire        = io.io_req_valid && io.io_req_ready;

  vec_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_flush),
    .push      (enq_fire && dec.legal),
    .push_data (dec.ent),
    .pop       (issue),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  // vd is checked too: WAW ordering, and it is a source for MADD/MACC.
  assign issue = !empty && !io_flush && !sb[head.vs1] && !sb[head.vs2] && !sb[head.vd];

  assign io.io_rf_raddr1   = head.vs1;
  assign io.io_rf_raddr2   = head.vs2;
  assign io.io_rf_raddr3   = head.vd;
  assign io.io_exe_valid   = issue;
  assign io.io_exe_bits_op = head.op;
  assign io.io_exe_bits_vd = head.vd;

  // Operand routing: MADD multiplies by vd and adds vs2, MACC accumulates into vd.
  always_comb begin
    io.io_exe_bits_a = io.io_rf_rdata1;
    io.io_exe_bits_b = io.io_rf_rdata2;
    io.io_exe_bits_c = '0;
    case (head.op)
      OP_VFMADD: begin
        io.io_exe_bits_b = io.io_rf_rdata3;
        io.io_exe_bits_c = io.io_rf_rdata2;
      end
      OP_VFMACC: io.io_exe_bits_c = io.io_rf_rdata3;
      default: ;
    endcase
  end

  // One-hot set on issue and clear on writeback for this edge.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (issue)          sb_set[head.vd]     = 1'b1;
    if (io.io_wb_valid) sb_clr[io.io_wb_vd] = 1'b1;
  end

  // Scoreboard: a set landing on the same edge as a clear wins.
  always_ff @(posedge clock or negedge reset)
    if (!reset) sb <= '0;
    else        sb <= (sb & ~sb_clr) | sb_set;

  // Rejected words pulse io_illegal for exactly the following cycle.
  always_ff @(posedge clock or negedge reset)
    if (!reset) io_illegal <= 1'b0;
    else        io_illegal <= enq_fire && !dec.legal;

  assign io_busy = !empty || (|sb);

endmodule

// File: tb/tb_vec_issue_unit.sv
// Directed bench for vec_issue_unit: decode/operand table plus hazard, full, flush and reset sequences.
module tb_vec_issue_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_flush = 1'b0;
  logic io_illegal, io_busy;
  int   errors = 0;
  int   checks = 0;

  vec_issue_unit_if ifc ();

  vec_issue_unit #(.DEPTH(4), .FPU_LAT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .io         (ifc),
    .io_flush   (io_flush),
    .io_illegal (io_illegal),
    .io_busy    (io_busy)
  );

  always #5 clock = ~clock;

  // Register file contents: v1=-100.0, v2=200.0, v5=1.0, others a tagged pattern.
  function automatic logic [31:0] rfv(input logic [4:0] a);
    case (a)
      5'd1:    return 32'hC2C80000;
      5'd2:    return 32'h43480000;
      5'd5:    return 32'h3F800000;
      default: return {24'hA0A0A0, 3'b000, a};
    endcase
  endfunction

  assign ifc.io_rf_rdata1 = rfv(ifc.io_rf_raddr1);
  assign ifc.io_rf_rdata2 = rfv(ifc.io_rf_raddr2);
  assign ifc.io_rf_rdata3 = rfv(ifc.io_rf_raddr3);

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                     input logic [4:0] vs1, input logic [2:0] f3,
                                     input logic [4:0] vd, input logic [6:0] opc);
    return {f6, vm, vs2, vs1, f3, vd, opc};
  endfunction

  function automatic logic [31:0] mkv(input logic [5:0] f6, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [4:0] vd);
    return mk(f6, 1'b1, vs2, vs1, 3'b001, vd, 7'b1010111);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic wb(input logic [4:0] vd);
    ifc.io_wb_valid = 1'b1;
    ifc.io_wb_vd    = vd;
    cyc();
    ifc.io_wb_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        legal;
    logic [2:0]  op;
    logic [31:0] a, b, c;
    logic [4:0]  vd;
  } vec_t;

  vec_t tbl [10];

  initial begin #200000; $display("FAIL timeout: bench did not finish"); $fatal(1); end

  initial begin
    ifc.io_req_valid     = 1'b0;
    ifc.io_req_bits_inst = '0;
    ifc.io_wb_valid      = 1'b0;
    ifc.io_wb_vd         = '0;

    tbl[0] = '{"vadd",     mkv(6'b000000, 5'd2, 5'd1, 5'd3), 1'b1, 3'd0, 32'hC2C80000, 32'h43480000, 32'h0, 5'd3};
    tbl[1] = '{"vfmin",    mkv(6'b000100, 5'd7, 5'd6, 5'd4), 1'b1, 3'd1, 32'hA0A0A006, 32'hA0A0A007, 32'h0, 5'd4};
    tbl[2] = '{"vfmax_vm0", mk(6'b000110, 1'b0, 5'd10, 5'd9, 3'b001, 5'd8, 7'b1010111),
               1'b1, 3'd2, 32'hA0A0A009, 32'hA0A0A00A, 32'h0, 5'd8};
    tbl[3] = '{"vfmul",    mkv(6'b100100, 5'd13, 5'd12, 5'd11), 1'b1, 3'd3, 32'hA0A0A00C, 32'hA0A0A00D, 32'h0, 5'd11};
    tbl[4] = '{"vfmadd",   mkv(6'b101000, 5'd2, 5'd1, 5'd5), 1'b1, 3'd4, 32'hC2C80000, 32'h3F800000, 32'h43480000, 5'd5};
    tbl[5] = '{"vfmacc",   mkv(6'b101100, 5'd2, 5'd1, 5'd5), 1'b1, 3'd5, 32'hC2C80000, 32'h43480000, 32'h3F800000, 5'd5};
    tbl[6] = '{"vadd_v31", mkv(6'b000000, 5'd30, 5'd0, 5'd31), 1'b1, 3'd0, 32'hA0A0A000, 32'hA0A0A01E, 32'h0, 5'd31};
    tbl[7] = '{"ill_f3",   mk(6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1010111), 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0};
    tbl[8] = '{"ill_opc",  mk(6'b000000, 1'b1, 5'd2, 5'd1, 3'b001, 5'd3, 7'b1010011), 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0};
    tbl[9] = '{"ill_f6",   mkv(6'b000010, 5'd2, 5'd1, 5'd3), 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0};

    // Reset state while reset is held.
    repeat (2) @(posedge clock);
    #2;
    chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
    chk("rst_sb", dut.sb, 32'd0);
    chk("rst_busy", io_busy, 1'b0);
    chk("rst_exe_valid", ifc.io_exe_valid, 1'b0);
    chk("rst_illegal", io_illegal, 1'b0);
    reset = 1'b1;
    cyc();
    #1 chk("rst_ready", ifc.io_req_ready, 1'b1);

    // Table: one instruction at a time into an idle unit.
    for (int i = 0; i < 10; i++) begin
      ifc.io_req_valid     = 1'b1;
      ifc.io_req_bits_inst = tbl[i].inst;
      cyc();
      ifc.io_req_valid = 1'b0;
      #1;
      if (tbl[i].legal) begin
        chk({tbl[i].name, "_valid"}, ifc.io_exe_valid, 1'b1);
        chk({tbl[i].name, "_op"}, ifc.io_exe_bits_op, tbl[i].op);
        chk({tbl[i].name, "_a"}, ifc.io_exe_bits_a, tbl[i].a);
        chk({tbl[i].name, "_b"}, ifc.io_exe_bits_b, tbl[i].b);
        chk({tbl[i].name, "_c"}, ifc.io_exe_bits_c, tbl[i].c);
        chk({tbl[i].name, "_vd"}, ifc.io_exe_bits_vd, tbl[i].vd);
        chk({tbl[i].name, "_illegal"}, io_illegal, 1'b0);
        cyc();
        #1 chk({tbl[i].name, "_once"}, ifc.io_exe_valid, 1'b0);
        chk({tbl[i].name, "_busy"}, io_busy, 1'b1);
        wb(tbl[i].vd);
        #1 chk({tbl[i].name, "_idle"}, io_busy, 1'b0);
      end else begin
        chk({tbl[i].name, "_illegal"}, io_illegal, 1'b1);
        chk({tbl[i].name, "_noexe"}, ifc.io_exe_valid, 1'b0);
        chk({tbl[i].name, "_count"}, 32'(dut.u_fifo.count), 32'd0);
        cyc();
        #1 chk({tbl[i].name, "_pulse1"}, io_illegal, 1'b0);
        chk({tbl[i].name, "_noexe2"}, ifc.io_exe_valid, 1'b0);
      end
    end

    // RAW: VFMUL v4 reading v3 waits for writeback of v3, then same-edge set/clear.
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd3);
    cyc();
    ifc.io_req_bits_inst = mkv(6'b100100, 5'd2, 5'd3, 5'd4);
    #1 chk("raw_first_vd", ifc.io_exe_valid ? 32'(ifc.io_exe_bits_vd) : 32'hFF, 32'd3);
    cyc();
    ifc.io_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("raw_stall", ifc.io_exe_valid, 1'b0);
      if (k < 3) cyc();
    end
    ifc.io_wb_valid = 1'b1;
    ifc.io_wb_vd    = 5'd3;
    #1 chk("raw_wb_cycle", ifc.io_exe_valid, 1'b0);
    cyc();
    ifc.io_wb_valid = 1'b0;
    #1 chk("raw_issue", ifc.io_exe_valid, 1'b1);
    chk("raw_op", ifc.io_exe_bits_op, 3'd3);
    chk("raw_a", ifc.io_exe_bits_a, 32'hA0A0A003);
    chk("raw_b", ifc.io_exe_bits_b, 32'h43480000);
    chk("raw_vd", ifc.io_exe_bits_vd, 5'd4);
    wb(5'd4);
    #1 chk("setclr_sb4", 32'(dut.sb[4]), 32'd1);
    chk("setclr_busy", io_busy, 1'b1);
    wb(5'd4);
    #1 chk("setclr_idle", io_busy, 1'b0);

    // Enqueue and issue on the same edge keep the count.
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd10);
    cyc();
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd11);
    #1 chk("enqiss_vd10", ifc.io_exe_bits_vd, 5'd10);
    cyc();
    ifc.io_req_valid = 1'b0;
    #1 chk("enqiss_count", 32'(dut.u_fifo.count), 32'd1);
    chk("enqiss_vd11", ifc.io_exe_valid ? 32'(ifc.io_exe_bits_vd) : 32'hFF, 32'd11);
    cyc();
    #1 chk("enqiss_drain", 32'(dut.u_fifo.count), 32'd0);
    wb(5'd10);
    wb(5'd11);
    #1 chk("enqiss_idle", io_busy, 1'b0);

    // Flush in the issue cycle suppresses the issue.
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd7);
    cyc();
    ifc.io_req_valid = 1'b0;
    io_flush = 1'b1;
    #1 chk("flush_noexe", ifc.io_exe_valid, 1'b0);
    chk("flush_ready", ifc.io_req_ready, 1'b0);
    cyc();
    io_flush = 1'b0;
    #1 chk("flush_nosb", io_busy, 1'b0);

    // Fill behind a stalled head, then flush; the sb bit survives until wb.
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd3);
    cyc();
    ifc.io_req_valid = 1'b0;
    cyc();
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b100100, 5'd2, 5'd3, 5'd4);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("full_ready%0d", k), ifc.io_req_ready, (k < 4) ? 1'b1 : 1'b0);
      cyc();
    end
    ifc.io_req_valid = 1'b0;
    #1 chk("full_count", 32'(dut.u_fifo.count), 32'd4);
    io_flush = 1'b1;
    #1 chk("full_flush_noexe", ifc.io_exe_valid, 1'b0);
    cyc();
    io_flush = 1'b0;
    #1 chk("full_flush_count", 32'(dut.u_fifo.count), 32'd0);
    chk("full_flush_sb3", 32'(dut.sb[3]), 32'd1);
    chk("full_flush_busy", io_busy, 1'b1);
    chk("full_flush_ready", ifc.io_req_ready, 1'b1);
    wb(5'd3);
    #1 chk("full_idle", io_busy, 1'b0);

    // Reset with three queued entries and one in flight.
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b000000, 5'd2, 5'd1, 5'd3);
    cyc();
    ifc.io_req_valid = 1'b0;
    cyc();
    ifc.io_req_valid = 1'b1;
    ifc.io_req_bits_inst = mkv(6'b100100, 5'd2, 5'd3, 5'd4);
    repeat (3) cyc();
    ifc.io_req_valid = 1'b0;
    #1 chk("rst3_count_pre", 32'(dut.u_fifo.count), 32'd3);
    reset = 1'b0;
    #1 chk("rst3_count", 32'(dut.u_fifo.count), 32'd0);
    chk("rst3_sb", dut.sb, 32'd0);
    chk("rst3_busy", io_busy, 1'b0);
    chk("rst3_exe", ifc.io_exe_valid, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    #1 chk("rst3_ready", ifc.io_req_ready, 1'b1);
    wb(5'd3);
    #1 chk("rst3_late_wb", io_busy, 1'b0);
    chk("rst3_late_sb", dut.sb, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
